// File: rtl/tail_light_seq.sv
// Tail-light sequencer datapath. Registers the state code from the upstream
// next-state logic and returns it as current_state. It also owns the lamp
// timebase, the left/right/hazard sequence counters and the registered
// LEDR lamp pattern.
//
//   state   | meaning
//   --------+---------------------------------------------
//   IDLE    | all lamps off
//   LEFT    | left group sequences, right group off
//   RIGHT   | right group sequences, left group off
//   LBREAK  | left group sequences, right group solid on
//   RBREAK  | right group sequences, left group solid on
//   BREAK   | both groups solid on
//   HAZARD  | both groups flash together at the lamp step rate
module tail_light_seq #(
  parameter int TICK_DIV = 12_500_000,
  parameter int PRE_W    = 24
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [2:0] next_state,
  input  logic       reset_count_rb,
  input  logic       reset_count_lb,
  input  logic       reset_count_h,
  output logic [2:0] current_state,
  output logic [9:0] LEDR
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEFT   = 3'd1,
    ST_RIGHT  = 3'd2,
    ST_LBREAK = 3'd3,
    ST_RBREAK = 3'd4,
    ST_BREAK  = 3'd5,
    ST_HAZARD = 3'd6
  } state_t;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [PRE_W-1:0] r_pre;
  logic             w_tick;
  logic             w_state_change;
  logic [1:0]       r_cnt_l;
  logic [1:0]       r_cnt_r;
  logic             r_haz;
  logic [9:0]       r_ledr;
  logic [9:0]       w_ledr;

  // Left group: inner lamp is the lowest bit of LEDR[9:7].
  function automatic logic [2:0] left_pattern(input logic [1:0] cnt);
    logic [2:0] pat;
    case (cnt)
      2'd0:    pat = 3'b000;
      2'd1:    pat = 3'b001;
      2'd2:    pat = 3'b011;
      default: pat = 3'b111;
    endcase
    return pat;
  endfunction

  // Right group: inner lamp is the highest bit of LEDR[2:0].
  function automatic logic [2:0] right_pattern(input logic [1:0] cnt);
    logic [2:0] pat;
    case (cnt)
      2'd0:    pat = 3'b000;
      2'd1:    pat = 3'b100;
      2'd2:    pat = 3'b110;
      default: pat = 3'b111;
    endcase
    return pat;
  endfunction

  // Decode the incoming code; the unused code 7 falls back to IDLE.
  always_comb begin
    w_next_state = ST_IDLE;
    case (next_state)
      3'd1:    w_next_state = ST_LEFT;
      3'd2:    w_next_state = ST_RIGHT;
      3'd3:    w_next_state = ST_LBREAK;
      3'd4:    w_next_state = ST_RBREAK;
      3'd5:    w_next_state = ST_BREAK;
      3'd6:    w_next_state = ST_HAZARD;
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_tick         = (r_pre == PRE_LAST);
  assign w_state_change = (w_next_state != r_state);

  // State register: follows the upstream next-state logic every edge.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Lamp timebase; restarts whenever the state changes so every new
  // sequence gets a full first step.
  always_ff @(posedge CLOCK_50) begin
    if (reset || w_state_change) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Sequence counters: the upstream clear wins over a coincident tick.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_cnt_l <= 2'd0;
      r_cnt_r <= 2'd0;
      r_haz   <= 1'b0;
    end else begin
      if (reset_count_lb) begin
        r_cnt_l <= 2'd0;
      end else if (w_tick) begin
        r_cnt_l <= r_cnt_l + 2'd1;
      end

      if (reset_count_rb) begin
        r_cnt_r <= 2'd0;
      end else if (w_tick) begin
        r_cnt_r <= r_cnt_r + 2'd1;
      end

      if (reset_count_h) begin
        r_haz <= 1'b0;
      end else if (w_tick) begin
        r_haz <= ~r_haz;
      end
    end
  end

  // Lamp pattern from the registered state and counters.
  always_comb begin
    w_ledr = 10'd0;
    case (r_state)
      ST_LEFT: begin
        w_ledr[9:7] = left_pattern(r_cnt_l);
      end
      ST_RIGHT: begin
        w_ledr[2:0] = right_pattern(r_cnt_r);
      end
      ST_LBREAK: begin
        w_ledr[9:7] = left_pattern(r_cnt_l);
        w_ledr[2:0] = 3'b111;
      end
      ST_RBREAK: begin
        w_ledr[9:7] = 3'b111;
        w_ledr[2:0] = right_pattern(r_cnt_r);
      end
      ST_BREAK: begin
        w_ledr[9:7] = 3'b111;
        w_ledr[2:0] = 3'b111;
      end
      ST_HAZARD: begin
        w_ledr[9:7] = {3{r_haz}};
        w_ledr[2:0] = {3{r_haz}};
      end
      default: begin
        w_ledr = 10'd0;
      end
    endcase
  end

  // Registered lamp outputs keep LEDR glitch-free and off the input paths.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_ledr <= 10'd0;
    end else begin
      r_ledr <= w_ledr;
    end
  end

  assign current_state = r_state;
  assign LEDR          = r_ledr;

endmodule

// File: tb/tb_tail_light_seq.sv
// Directed bench for tail_light_seq with a 4-cycle lamp step.
module tb_tail_light_seq;

  logic       clk;
  logic       reset;
  logic [2:0] next_state;
  logic       reset_count_rb;
  logic       reset_count_lb;
  logic       reset_count_h;
  logic [2:0] current_state;
  logic [9:0] LEDR;

  int total = 0;
  int bad   = 0;

  tail_light_seq #(.TICK_DIV(4), .PRE_W(3)) dut (
    .CLOCK_50      (clk),
    .reset         (reset),
    .next_state    (next_state),
    .reset_count_rb(reset_count_rb),
    .reset_count_lb(reset_count_lb),
    .reset_count_h (reset_count_h),
    .current_state (current_state),
    .LEDR          (LEDR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are changed and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counter level seen on LEDR k edges after current_state changed
  // (TICK_DIV=4): steps at k=5, 9, 13, 17 ...
  function automatic int level(input int k);
    if (k < 5) return 0;
    return ((k - 5) / 4 + 1) % 4;
  endfunction

  function automatic logic [2:0] lpat(input int lvl);
    case (lvl)
      0:       return 3'b000;
      1:       return 3'b001;
      2:       return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [2:0] rpat(input int lvl);
    case (lvl)
      0:       return 3'b000;
      1:       return 3'b100;
      2:       return 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1; next_state = 3'd0;
    reset_count_lb = 1'b1; reset_count_rb = 1'b1; reset_count_h = 1'b1;
    step(); step();
    total++;
    if (current_state !== 3'd0) begin
      bad++; $display("FAIL reset_state got=%0d exp=0", current_state);
    end
    total++;
    if (LEDR !== 10'h000) begin
      bad++; $display("FAIL reset_ledr got=%h exp=000", LEDR);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if (current_state !== 3'd0 || LEDR !== 10'h000) begin
        bad++;
        $display("FAIL idle_hold cyc=%0d state=%0d ledr=%h exp state=0 ledr=000", i, current_state, LEDR);
      end
    end
  endtask

  task automatic test_left();
    logic [9:0] exp;
    next_state = 3'd1; reset_count_lb = 1'b1; reset_count_rb = 1'b1; reset_count_h = 1'b1;
    step();
    total++;
    if (current_state !== 3'd1) begin
      bad++; $display("FAIL left_enter got=%0d exp=1", current_state);
    end
    reset_count_lb = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      step();
      exp = {lpat(level(k)), 4'b0000, 3'b000};
      total++;
      if (LEDR !== exp) begin
        bad++; $display("FAIL left_seq k=%0d got=%h exp=%h", k, LEDR, exp);
      end
    end
  endtask

  task automatic test_rbreak();
    logic [9:0] exp;
    next_state = 3'd4; reset_count_lb = 1'b1; reset_count_rb = 1'b1; reset_count_h = 1'b1;
    step();
    total++;
    if (current_state !== 3'd4) begin
      bad++; $display("FAIL rbreak_enter got=%0d exp=4", current_state);
    end
    reset_count_rb = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      step();
      exp = {3'b111, 4'b0000, rpat(level(k))};
      total++;
      if (LEDR !== exp) begin
        bad++; $display("FAIL rbreak_seq k=%0d got=%h exp=%h", k, LEDR, exp);
      end
    end
  endtask

  task automatic test_hazard_break();
    logic [9:0] exp;
    next_state = 3'd6; reset_count_lb = 1'b1; reset_count_rb = 1'b1; reset_count_h = 1'b1;
    step();
    total++;
    if (current_state !== 3'd6) begin
      bad++; $display("FAIL hazard_enter got=%0d exp=6", current_state);
    end
    reset_count_h = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      step();
      if (k < 5) exp = 10'h000;
      else exp = (((k - 5) / 4) % 2 == 0) ? 10'h387 : 10'h000;
      total++;
      if (LEDR !== exp) begin
        bad++; $display("FAIL hazard_seq k=%0d got=%h exp=%h", k, LEDR, exp);
      end
    end
    next_state = 3'd5; reset_count_h = 1'b1;
    step();
    for (int k = 1; k <= 6; k++) begin
      step();
      total++;
      if (LEDR !== 10'h387 || current_state !== 3'd5) begin
        bad++; $display("FAIL break_steady k=%0d state=%0d ledr=%h exp state=5 ledr=387", k, current_state, LEDR);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp;
    next_state = 3'd1; reset_count_lb = 1'b1; reset_count_rb = 1'b1; reset_count_h = 1'b1;
    step();
    reset_count_lb = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp = {lpat(level(k)), 7'd0};
      total++;
      if (LEDR !== exp) begin
        bad++; $display("FAIL b2b_left k=%0d got=%h exp=%h", k, LEDR, exp);
      end
    end
    // cnt_l has just reached 2 and the prescaler is back at 0.
    next_state = 3'd2; reset_count_lb = 1'b1; reset_count_rb = 1'b0;
    step();
    total++;
    if (current_state !== 3'd2 || LEDR !== 10'h180) begin
      bad++; $display("FAIL b2b_switch state=%0d ledr=%h exp state=2 ledr=180", current_state, LEDR);
    end
    for (int k = 1; k <= 9; k++) begin
      step();
      exp = {7'd0, rpat(level(k))};
      total++;
      if (LEDR !== exp) begin
        bad++; $display("FAIL b2b_right k=%0d got=%h exp=%h", k, LEDR, exp);
      end
    end
  endtask

  task automatic test_reset_mid_hazard();
    next_state = 3'd6; reset_count_lb = 1'b1; reset_count_rb = 1'b1; reset_count_h = 1'b1;
    step();
    reset_count_h = 1'b0;
    for (int k = 1; k <= 5; k++) step();
    total++;
    if (LEDR !== 10'h387) begin
      bad++; $display("FAIL haz_before_reset got=%h exp=387", LEDR);
    end
    reset = 1'b1;
    step();
    total++;
    if (LEDR !== 10'h000 || current_state !== 3'd0) begin
      bad++; $display("FAIL haz_reset state=%0d ledr=%h exp state=0 ledr=000", current_state, LEDR);
    end
    reset = 1'b0; next_state = 3'd7;
    step();
    total++;
    if (current_state !== 3'd0) begin
      bad++; $display("FAIL code7_state got=%0d exp=0", current_state);
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      total++;
      if (LEDR !== 10'h000 || current_state !== 3'd0) begin
        bad++; $display("FAIL code7_hold k=%0d state=%0d ledr=%h exp state=0 ledr=000", k, current_state, LEDR);
      end
    end
  endtask

  initial begin
    test_reset();
    test_left();
    test_rbreak();
    test_hazard_break();
    test_back_to_back();
    test_reset_mid_hazard();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
